// File: rtl/io_timer_device.sv
`default_nettype none
// ============================================================================
// Module      : io_timer_device
// Description : Bus-mapped down-counting timer with prescaler, one-shot or
//               periodic mode, sticky expiry flag and level interrupt.
//               Registers: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS, 4 PRESCALE.
// Revision    : 1.0 - initial release
// ============================================================================
module io_timer_device #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wt_io,
  input  logic        rd_io,
  input  logic [3:0]  register_addr,
  inout  wire  [31:0] data,
  output logic        irq
);

  localparam logic [3:0] c_addr_ctrl   = 4'd0;
  localparam logic [3:0] c_addr_load   = 4'd1;
  localparam logic [3:0] c_addr_count  = 4'd2;
  localparam logic [3:0] c_addr_status = 4'd3;
  localparam logic [3:0] c_addr_presc  = 4'd4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_periodic, w_periodic_nxt;
  logic             r_irq_en,   w_irq_en_nxt;
  logic             r_expired,  w_expired_nxt;
  logic             r_irq,      w_irq_nxt;
  logic [CNT_W-1:0] r_load,     w_load_nxt;
  logic [CNT_W-1:0] r_count,    w_count_nxt;
  logic [CNT_W-1:0] r_prescale, w_prescale_nxt;
  logic [CNT_W-1:0] r_presc,    w_presc_nxt;

  logic             w_wr;
  logic             w_rd;
  logic             w_wr_ctrl;
  logic             w_wr_load;
  logic             w_wr_status;
  logic             w_wr_presc;
  logic             w_start;
  logic             w_stop;
  logic             w_tick;
  logic             w_expire;
  logic [31:0]      w_rd_data;

  // A simultaneous write and read strobe is a write; the bus is never driven then.
  assign w_wr        = cs & wt_io;
  assign w_rd        = rst_n & cs & rd_io & ~wt_io;
  assign w_wr_ctrl   = w_wr && (register_addr == c_addr_ctrl);
  assign w_wr_load   = w_wr && (register_addr == c_addr_load);
  assign w_wr_status = w_wr && (register_addr == c_addr_status);
  assign w_wr_presc  = w_wr && (register_addr == c_addr_presc);

  assign w_start  = w_wr_ctrl &&  data[0] && (r_state == ST_IDLE);
  assign w_stop   = w_wr_ctrl && !data[0] && (r_state == ST_RUN);
  // '>=' rather than '==' so that lowering PRESCALE below the running
  // prescaler value ticks at once instead of waiting for a full wrap.
  assign w_tick   = (r_state == ST_RUN) && !w_stop && (r_presc >= r_prescale);
  assign w_expire = w_tick && (r_count == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: start from IDLE, leave RUN on stop or one-shot expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_expire && !r_periodic) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values: register writes, prescaler, count and expiry flag.
  always_comb begin
    w_periodic_nxt = r_periodic;
    w_irq_en_nxt   = r_irq_en;
    w_expired_nxt  = r_expired;
    w_load_nxt     = r_load;
    w_count_nxt    = r_count;
    w_prescale_nxt = r_prescale;
    w_presc_nxt    = r_presc;

    if (w_wr_ctrl) begin
      w_periodic_nxt = data[1];
      w_irq_en_nxt   = data[2];
    end
    if (w_wr_load) begin
      w_load_nxt = data[CNT_W-1:0];
    end
    if (w_wr_presc) begin
      w_prescale_nxt = data[CNT_W-1:0];
    end
    if (w_wr_status && data[0]) begin
      w_expired_nxt = 1'b0;
    end

    if (w_start) begin
      w_count_nxt = w_load_nxt;
      w_presc_nxt = '0;
    end else if ((r_state == ST_RUN) && !w_stop) begin
      if (w_tick) begin
        w_presc_nxt = '0;
        if (r_count != '0) begin
          w_count_nxt = r_count - CNT_W'(1);
        end else begin
          // Set beats a same-cycle write-1-to-clear.
          w_expired_nxt = 1'b1;
          if (r_periodic) begin
            w_count_nxt = r_load;
          end
        end
      end else begin
        w_presc_nxt = r_presc + CNT_W'(1);
      end
    end

    w_irq_nxt = w_expired_nxt & w_irq_en_nxt;
  end

  // Datapath registers; irq is flopped so the pin never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_periodic <= 1'b0;
      r_irq_en   <= 1'b0;
      r_expired  <= 1'b0;
      r_irq      <= 1'b0;
      r_load     <= '0;
      r_count    <= '0;
      r_prescale <= '0;
      r_presc    <= '0;
    end else begin
      r_periodic <= w_periodic_nxt;
      r_irq_en   <= w_irq_en_nxt;
      r_expired  <= w_expired_nxt;
      r_irq      <= w_irq_nxt;
      r_load     <= w_load_nxt;
      r_count    <= w_count_nxt;
      r_prescale <= w_prescale_nxt;
      r_presc    <= w_presc_nxt;
    end
  end

  // Read mux: addressed register zero-extended, unmapped addresses read 0.
  always_comb begin
    w_rd_data = '0;
    case (register_addr)
      c_addr_ctrl:   w_rd_data[2:0]       = {r_irq_en, r_periodic, (r_state == ST_RUN)};
      c_addr_load:   w_rd_data[CNT_W-1:0] = r_load;
      c_addr_count:  w_rd_data[CNT_W-1:0] = r_count;
      c_addr_status: w_rd_data[0]         = r_expired;
      c_addr_presc:  w_rd_data[CNT_W-1:0] = r_prescale;
      default:       w_rd_data            = '0;
    endcase
  end

  assign data = w_rd ? w_rd_data : 32'bz;
  assign irq  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_timer_device.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_timer_device
// Description : Self-checking bench for io_timer_device. An arithmetic model
//               of the timer is compared against irq and every bus read on
//               each falling edge; directed literals pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_timer_device;

  logic        clk     = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst_n;
  logic        cs, wt_io, rd_io;
  logic [3:0]  register_addr;
  wire  [31:0] data;
  logic        irq;
  logic        tb_drv;
  logic [31:0] tb_wdata;

  int checks = 0;
  int errors = 0;

  assign data = tb_drv ? tb_wdata : 32'bz;

  io_timer_device #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cs           (cs),
    .wt_io        (wt_io),
    .rd_io        (rd_io),
    .register_addr(register_addr),
    .data         (data),
    .irq          (irq)
  );

  // Gateable clock so the reset test can freeze it.
  always #5 if (clk_run) clk = ~clk;

  // ---------------- behavioural model ----------------
  // A run segment is described by the count at its start (m_c0) and the
  // number of RUN edges since (m_e); COUNT is derived arithmetically.
  logic        m_run = 1'b0, m_per = 1'b0, m_ien = 1'b0, m_exp = 1'b0;
  logic [31:0] m_load = '0, m_pre = '0, m_c0 = '0;
  longint      m_e = 0;

  function automatic logic [31:0] m_count();
    longint t, n, c;
    if (!m_run) return m_c0;
    t = m_e / (longint'(m_pre) + 1);
    c = longint'(m_c0);
    n = longint'(m_load);
    if (t <= c) return 32'(c - t);
    return 32'(n - ((t - c - 1) % (n + 1)));
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a)
      4'd0:    return {29'd0, m_ien, m_per, m_run};
      4'd1:    return m_load;
      4'd2:    return m_count();
      4'd3:    return {31'd0, m_exp};
      4'd4:    return m_pre;
      default: return 32'd0;
    endcase
  endfunction

  // Model update on every clock edge, async reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_per = 0; m_ien = 0; m_exp = 0;
      m_load = 0; m_pre = 0; m_c0 = 0; m_e = 0;
    end else begin : step
      logic        was_run, wr, stop, expire;
      logic [3:0]  a;
      logic [31:0] d;
      longint      p1, t;
      was_run = m_run;
      wr      = cs && wt_io;
      a       = register_addr;
      d       = data;
      expire  = 1'b0;
      stop    = wr && (a == 4'd0) && !d[0] && m_run;
      if (stop) begin
        m_c0  = m_count();
        m_run = 1'b0;
      end else if (m_run) begin
        m_e = m_e + 1;
        p1  = longint'(m_pre) + 1;
        if ((m_e % p1) == 0) begin
          t = m_e / p1;
          if (t > longint'(m_c0) &&
              ((t - longint'(m_c0) - 1) % (longint'(m_load) + 1)) == 0) begin
            expire = 1'b1;
            if (!m_per) begin
              m_run = 1'b0;
              m_c0  = 32'd0;
            end
          end
        end
      end
      if (wr) begin
        case (a)
          4'd0: begin
            m_per = d[1];
            m_ien = d[2];
            if (d[0] && !was_run) begin
              m_run = 1'b1;
              m_e   = 0;
              m_c0  = m_load;
            end
          end
          4'd1: m_load = d;
          4'd3: if (d[0] && !expire) m_exp = 1'b0;
          4'd4: m_pre = d;
          default: ;
        endcase
      end
      if (expire) m_exp = 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Compare process: irq every cycle, bus data whenever a read is presented.
  initial forever begin
    @(negedge clk);
    chk("irq_vs_model", {31'd0, irq}, {31'd0, m_exp & m_ien});
    if (rst_n && cs && rd_io && !wt_io)
      chk($sformatf("read_vs_model_a%0d", register_addr), data, m_read(register_addr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    cs = 1'b1; wt_io = 1'b0; rd_io = 1'b1; register_addr = 4'd2;
    tb_drv = 1'b0; tb_wdata = 32'd0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; wt_io = 1'b1; rd_io = 1'b0; register_addr = a;
    tb_wdata = d; tb_drv = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
    cs = 1'b1; wt_io = 1'b0; rd_io = 1'b1; tb_drv = 1'b0; register_addr = a;
    #1;
    chk(name, data, exp);
    register_addr = 4'd2;
  endtask

  task automatic chk_irq(input logic exp, input string name);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // The bus must not carry the (non-zero) COUNT value when it is released.
  task automatic chk_released(input logic c, input logic w, input logic [31:0] held,
                              input string name);
    cs = c; wt_io = w; rd_io = 1'b1; tb_drv = 1'b0; register_addr = 4'd2;
    #1;
    checks++;
    if (data === held) begin
      errors++;
      $display("FAIL %s: bus shows %h, expected released", name, data);
    end
    idle();
  endtask

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk_rd(4'd0, 32'd0, "rst_ctrl");
    chk_rd(4'd1, 32'd0, "rst_load");
    chk_rd(4'd2, 32'd0, "rst_count");
    chk_rd(4'd3, 32'd0, "rst_status");
    chk_rd(4'd4, 32'd0, "rst_prescale");
    chk_irq(1'b0, "rst_irq");

    // One-shot: LOAD=3, PRESCALE=0, CTRL=0x5 -> expiry 4 cycles after RUN entry
    wr(4'd1, 32'd3);
    wr(4'd4, 32'd0);
    wr(4'd0, 32'h5);
    cyc(3);
    chk_irq(1'b0, "oneshot_irq_before");
    chk_rd(4'd2, 32'd0, "oneshot_count_c3");
    chk_rd(4'd3, 32'd0, "oneshot_status_before");
    cyc(1);
    chk_irq(1'b1, "oneshot_irq_at_expiry");
    chk_rd(4'd3, 32'd1, "oneshot_status_at_expiry");
    chk_rd(4'd0, 32'h4, "oneshot_en_cleared");
    chk_rd(4'd2, 32'd0, "oneshot_count_zero");
    cyc(2);
    chk_rd(4'd2, 32'd0, "oneshot_count_no_wrap");
    wr(4'd3, 32'd1);
    chk_irq(1'b0, "oneshot_irq_cleared");
    chk_rd(4'd3, 32'd0, "oneshot_status_cleared");

    // Periodic: LOAD=1, PRESCALE=2, CTRL=0x3 -> 1,0,1,0 with 3 cycles each
    wr(4'd1, 32'd1);
    wr(4'd4, 32'd2);
    wr(4'd0, 32'h3);
    chk_rd(4'd2, 32'd1, "per_count_c0");
    cyc(2);
    chk_rd(4'd2, 32'd1, "per_count_c2");
    cyc(1);
    chk_rd(4'd2, 32'd0, "per_count_c3");
    chk_rd(4'd3, 32'd0, "per_status_c3");
    cyc(2);
    chk_rd(4'd2, 32'd0, "per_count_c5");
    cyc(1);
    chk_rd(4'd2, 32'd1, "per_count_c6");
    chk_rd(4'd3, 32'd1, "per_status_c6");
    chk_rd(4'd0, 32'h3, "per_still_run");
    wr(4'd3, 32'd1);
    chk_rd(4'd3, 32'd0, "per_status_clear_c7");
    cyc(4);
    wr(4'd3, 32'd1);
    chk_rd(4'd3, 32'd1, "set_beats_clear_c12");
    chk_irq(1'b0, "per_irq_masked");
    wr(4'd0, 32'h7);
    chk_irq(1'b1, "per_irq_enabled");
    chk_rd(4'd0, 32'h7, "per_ctrl_update");
    wr(4'd3, 32'd1);
    chk_irq(1'b0, "per_irq_cleared");
    chk_rd(4'd3, 32'd0, "per_status_cleared");
    wr(4'd0, 32'h0);
    chk_rd(4'd0, 32'h0, "per_stopped_ctrl");

    // Stop/hold: LOAD=10, CTRL=0x1, stop after 4 cycles -> holds 6
    wr(4'd4, 32'd0);
    wr(4'd1, 32'd10);
    wr(4'd0, 32'h1);
    cyc(4);
    wr(4'd0, 32'h0);
    chk_rd(4'd2, 32'd6, "hold_count");
    cyc(3);
    chk_rd(4'd2, 32'd6, "hold_count_later");

    // Bus behaviour
    chk_rd(4'd9, 32'd0, "unmapped_read");
    chk_released(1'b0, 1'b0, 32'd6, "release_cs_low");
    chk_released(1'b1, 1'b1, 32'd6, "release_write_strobe");
    chk_rd(4'd1, 32'd10, "load_readback");
    wr(4'd9, 32'hFFFF_FFFF);
    chk_rd(4'd9, 32'd0, "unmapped_write_ignored");
    wr(4'd2, 32'h55);
    chk_rd(4'd2, 32'd6, "count_read_only");

    // Restart reloads; EN=1 rewrite in RUN keeps counting
    wr(4'd0, 32'h1);
    chk_rd(4'd2, 32'd10, "restart_reload");
    wr(4'd0, 32'h7);
    chk_rd(4'd2, 32'd9, "rewrite_no_restart");
    cyc(10);
    chk_irq(1'b1, "rewrite_irq_at_expiry");
    chk_rd(4'd2, 32'd10, "rewrite_periodic_reload");
    cyc(3);
    chk_rd(4'd2, 32'd7, "mid_count_before_reset");

    // Asynchronous reset with the clock frozen
    @(negedge clk);
    clk_run = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_irq(1'b0, "async_rst_irq");
    #2 rst_n = 1'b1;
    #1;
    chk_rd(4'd0, 32'd0, "post_rst_ctrl");
    chk_rd(4'd1, 32'd0, "post_rst_load");
    chk_rd(4'd2, 32'd0, "post_rst_count");
    chk_rd(4'd3, 32'd0, "post_rst_status");
    chk_rd(4'd4, 32'd0, "post_rst_prescale");
    clk_run = 1'b1;
    cyc(30);
    chk_rd(4'd3, 32'd0, "no_expiry_after_rst");
    chk_rd(4'd0, 32'd0, "idle_after_rst");
    chk_irq(1'b0, "irq_after_rst");

    // Normal operation resumes: LOAD=2 expires 3 cycles after RUN entry
    wr(4'd1, 32'd2);
    wr(4'd0, 32'h5);
    cyc(2);
    chk_irq(1'b0, "resume_irq_before");
    cyc(1);
    chk_irq(1'b1, "resume_irq_at_expiry");
    chk_rd(4'd0, 32'h4, "resume_en_cleared");

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/io_timer_device.md
IO_TIMER_DEVICE -- requirements
Module: io_timer_device

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of LOAD, COUNT and PRESCALE (1..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port cs, input, 1, this device's chip-select bit from the IO controller.
REQ-005 SHALL have port wt_io, input, 1, bus write strobe.
REQ-006 SHALL have port rd_io, input, 1, bus read strobe.
REQ-007 SHALL have port register_addr, input, 4, register index within the device.
REQ-008 SHALL have port data, inout, 32, shared IO data bus.
REQ-009 SHALL have port irq, output, 1, level interrupt request.

Function
REQ-010 SHALL map registers as: 0 CTRL (RW, bit0 EN, bit1 PERIODIC, bit2 IRQ_EN), 1 LOAD (RW), 2 COUNT (RO), 3 STATUS (bit0 EXPIRED, write-1-to-clear), 4 PRESCALE (RW); addresses 5..15 read 0 and ignore writes.
REQ-011 SHALL capture a write on the clk edge where cs=1 and wt_io=1, using data[CNT_W-1:0]; unused upper CTRL/STATUS bits read 0.
REQ-012 SHALL drive data combinationally with the addressed register, zero-extended to 32 bits, when cs=1, rd_io=1 and wt_io=0; otherwise data SHALL be high-impedance.
REQ-013 SHALL treat cs=1 with wt_io=1 and rd_io=1 as a write only (no drive).
REQ-014 SHALL implement FSM states IDLE and RUN; reset state IDLE.
REQ-015 SHALL, on a CTRL write with EN=1 while in IDLE: load COUNT from LOAD (value after any same-cycle write), clear prescaler to 0, go to RUN on the next cycle.
REQ-016 SHALL, in RUN, increment the prescaler each cycle; a tick occurs when prescaler equals PRESCALE, after which prescaler returns to 0 (PRESCALE=0 gives a tick every cycle).
REQ-017 SHALL, on a tick with COUNT!=0, decrement COUNT by 1.
REQ-018 SHALL, on a tick with COUNT==0, set STATUS.EXPIRED; if PERIODIC=1 reload COUNT from LOAD and stay in RUN; else clear CTRL.EN and go to IDLE with COUNT held at 0.
REQ-019 SHALL make LOAD=N with PRESCALE=P expire (N+1)*(P+1) cycles after the first RUN cycle; LOAD=0 expires on the first tick.
REQ-020 SHALL, on a CTRL write with EN=0 while in RUN, go to IDLE and hold COUNT and prescaler values.
REQ-021 SHALL, on a CTRL write with EN=1 while in RUN, update PERIODIC/IRQ_EN only, without restarting the count.
REQ-022 SHALL apply LOAD writes during RUN only at the next reload or start; PRESCALE writes take effect on the next prescaler compare.
REQ-023 SHALL give the set priority when an expiry and a STATUS write-1 to bit0 occur in the same cycle (EXPIRED stays 1).
REQ-024 SHALL drive irq = STATUS.EXPIRED & CTRL.IRQ_EN, registered-source and glitch-free, held until cleared.
REQ-025 SHALL make COUNT wrap-free: it never decrements below 0.

Reset
REQ-026 SHALL, on rst_n=0 regardless of clk: state IDLE; CTRL, LOAD, COUNT, STATUS, PRESCALE and prescaler = 0; irq = 0; data high-impedance.
REQ-027 SHALL abort a running count on reset mid-operation, with no expiry flagged, and resume normal operation on the first clk edge after rst_n rises.

Verification
REQ-028 SHALL cover: write LOAD=3, PRESCALE=0, CTRL=0x5 -> EXPIRED=1 and irq=1 exactly 4 cycles after RUN entry, EN reads 0, COUNT reads 0.
REQ-029 SHALL cover: LOAD=1, PRESCALE=2, CTRL=0x3 -> EXPIRED sets every 6 cycles, COUNT sequence 1,0,1,0 with 3 cycles per value, state stays RUN.
REQ-030 SHALL cover: STATUS write 0x1 in the same cycle as expiry -> EXPIRED stays 1; a later write 0x1 clears it and irq to 0.
REQ-031 SHALL cover: read addr 2 with cs=1, rd_io=1 -> data=COUNT; cs=0 or wt_io=1 -> data=Z; read addr 9 -> 0x00000000.
REQ-032 SHALL cover: CTRL=0x1 with LOAD=10, write CTRL=0 after 4 cycles -> COUNT holds at 6; rewrite CTRL=0x1 -> COUNT reloads 10.
REQ-033 SHALL cover: rst_n low mid-count with clk stopped -> all registers read 0 immediately, irq=0, no expiry flagged after release.
